// File: rtl/line_mem_responder.sv
// Line-granular backing store for the cache miss path: line fills and dirty-line writebacks.
// Optional byte-lane write strobes are enabled with the BYTE_STRB_EN macro.
module line_mem_responder #(
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 32,
  parameter int BEATS   = 4,
  parameter int LATENCY = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_v,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_rdy,
  input  logic              wr_v,
  input  logic [DATA_W-1:0] wr_data,
`ifdef BYTE_STRB_EN
  input  logic [DATA_W/8-1:0] wr_strb,
`endif
  output logic              wr_rdy,
  output logic              rd_v,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              done,
  output logic              busy
);

  localparam int BEAT_W = $clog2(BEATS);
  localparam int LAT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int IDX_W  = ADDR_W + BEAT_W;
  localparam int DEPTH  = 1 << IDX_W;
  localparam int NBYTES = DATA_W / 8;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [LAT_W-1:0]  LAT_LOAD  = LAT_W'(LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_RBURST,
    S_WBURST,
    S_DONE
  } state_t;

  state_t              state, state_nxt;
  logic [LAT_W-1:0]    lat_cnt, lat_nxt;
  logic [BEAT_W-1:0]   beat, beat_nxt;
  logic [ADDR_W-1:0]   addr_q, addr_nxt;
  logic                we_q, we_nxt;
  logic                wr_en;
  logic [IDX_W-1:0]    idx;

  logic [DATA_W-1:0]   mem [DEPTH];

  // Lines are stored contiguously, so {line, beat} never crosses into a neighbour.
  assign idx = {addr_q, beat};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours, independent of block order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      lat_cnt <= '0;
      beat    <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
    end else begin
      state   <= state_nxt;
      lat_cnt <= lat_nxt;
      beat    <= beat_nxt;
      addr_q  <= addr_nxt;
      we_q    <= we_nxt;
    end
  end

  // NOTE: every output of this block gets a default first; a path that leaves
  // one unassigned would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    lat_nxt   = lat_cnt;
    beat_nxt  = beat;
    addr_nxt  = addr_q;
    we_nxt    = we_q;
    req_rdy   = 1'b0;
    busy      = 1'b1;
    wr_rdy    = 1'b0;
    rd_v      = 1'b0;
    rd_last   = 1'b0;
    done      = 1'b0;
    wr_en     = 1'b0;

    unique case (state)
      S_IDLE: begin
        req_rdy = 1'b1;
        busy    = 1'b0;
        if (req_v) begin
          addr_nxt  = req_addr;
          we_nxt    = req_we;
          lat_nxt   = LAT_LOAD;
          state_nxt = S_WAIT;
        end
      end

      S_WAIT: begin
        if (lat_cnt == '0) begin
          beat_nxt  = '0;
          state_nxt = we_q ? S_WBURST : S_RBURST;
        end else begin
          lat_nxt = lat_cnt - LAT_W'(1);
        end
      end

      S_RBURST: begin
        rd_v     = 1'b1;
        rd_last  = (beat == LAST_BEAT);
        beat_nxt = beat + BEAT_W'(1);
        if (beat == LAST_BEAT) state_nxt = S_DONE;
      end

      S_WBURST: begin
        wr_rdy = 1'b1;
        // A stalled writer simply holds the burst open; there is no timeout.
        if (wr_v) begin
          wr_en    = 1'b1;
          beat_nxt = beat + BEAT_W'(1);
          if (beat == LAST_BEAT) state_nxt = S_DONE;
        end
      end

      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: the array is deliberately left out of reset so its contents survive
  // a reset pulse; write enables are gated by state, which reset forces to IDLE.
`ifdef BYTE_STRB_EN
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (wr_strb[b]) mem[idx][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (wr_en) mem[idx] <= wr_data;
  end
`endif

  // Don't-care outside RBURST; the consumer qualifies it with rd_v.
  assign rd_data = mem[idx];

endmodule

// File: tb/tb_line_mem_responder.sv
// Directed scoreboard bench for line_mem_responder; define BYTE_STRB_EN to cover write strobes.
module tb_line_mem_responder;
  localparam int ADDR_W  = 6;
  localparam int DATA_W  = 32;
  localparam int BEATS   = 4;
  localparam int LATENCY = 3;
  localparam int LINES   = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              req_v = 1'b0;
  logic              req_we = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic              req_rdy;
  logic              wr_v = 1'b0;
  logic [DATA_W-1:0] wr_data = '0;
  logic [3:0]        wr_strb = 4'hF;
  logic              wr_rdy;
  logic              rd_v;
  logic [DATA_W-1:0] rd_data;
  logic              rd_last;
  logic              done;
  logic              busy;

  line_mem_responder #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .BEATS  (BEATS),
    .LATENCY(LATENCY)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req_v   (req_v),
    .req_we  (req_we),
    .req_addr(req_addr),
    .req_rdy (req_rdy),
    .wr_v    (wr_v),
    .wr_data (wr_data),
`ifdef BYTE_STRB_EN
    .wr_strb (wr_strb),
`endif
    .wr_rdy  (wr_rdy),
    .rd_v    (rd_v),
    .rd_data (rd_data),
    .rd_last (rd_last),
    .done    (done),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;

  beat_t             sb[$];
  logic [DATA_W-1:0] model [LINES*BEATS];
  int                checks = 0;
  int                failures = 0;
  int                cyc_n = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock; sample #1 after the edge and score any fill beat.
  task automatic cyc();
    @(posedge clk);
    #1;
    cyc_n++;
    if (rd_v) begin
      if (sb.size() == 0) begin
        check("rd_unexpected", 32'd1, 32'd0);
      end else begin
        beat_t e;
        e = sb.pop_front();
        check("rd_data", rd_data, e.data);
        check("rd_last", {31'd0, rd_last}, {31'd0, e.last});
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_rdy"}, {31'd0, req_rdy}, 32'd1);
    check({tag, "_busy"},    {31'd0, busy},    32'd0);
    check({tag, "_wr_rdy"},  {31'd0, wr_rdy},  32'd0);
    check({tag, "_rd_v"},    {31'd0, rd_v},    32'd0);
    check({tag, "_rd_last"}, {31'd0, rd_last}, 32'd0);
    check({tag, "_done"},    {31'd0, done},    32'd0);
  endtask

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_w,
                                              input logic [DATA_W-1:0] new_w,
                                              input logic [3:0] strb);
    logic [DATA_W-1:0] m;
    for (int b = 0; b < 4; b++) m[b*8 +: 8] = {8{strb[b]}};
`ifdef BYTE_STRB_EN
    return (old_w & ~m) | (new_w & m);
`else
    return new_w;
`endif
  endfunction

  // Writeback of base+i; optional stall of stall_len cycles after beat stall_after.
  task automatic write_line(input int a, input logic [DATA_W-1:0] base, input int stall_after,
                            input int stall_len, input int exp_done, input logic [3:0] strb);
    int i;
    int stall;
    logic acc;
    req_v = 1'b1; req_we = 1'b1; req_addr = ADDR_W'(a);
    wr_v = 1'b1; wr_data = 32'hBAD0_0000; wr_strb = strb;
    check("wb_req_rdy_idle", {31'd0, req_rdy}, 32'd1);
    cyc_n = 0;
    cyc();
    req_v = 1'b0;
    check("wb_busy_wait", {31'd0, busy}, 32'd1);
    check("wb_req_rdy_wait", {31'd0, req_rdy}, 32'd0);
    while (!wr_rdy && cyc_n < 20) cyc();
    check("wb_wr_rdy_cycle", cyc_n, LATENCY + 1);
    i = 0;
    stall = 0;
    while (i < BEATS && cyc_n < 40) begin
      if (stall > 0) begin
        wr_v = 1'b0; wr_data = 32'hDEAD_BEEF; stall--;
      end else begin
        wr_v = 1'b1; wr_data = base + 32'(i);
      end
      acc = wr_v && wr_rdy;
      cyc();
      if (acc) begin
        model[a*BEATS+i] = merge(model[a*BEATS+i], base + 32'(i), strb);
        if (i == stall_after) stall = stall_len;
        i++;
      end
    end
    check("wb_beats", i, BEATS);
    // Keep wr_v high with junk through DONE: it must not write.
    wr_data = 32'h0BAD_0BAD;
    check("wb_done_cycle", cyc_n, exp_done);
    check("wb_done", {31'd0, done}, 32'd1);
    check("wb_wr_rdy_done", {31'd0, wr_rdy}, 32'd0);
    cyc();
    wr_v = 1'b0;
    check("wb_done_pulse", {31'd0, done}, 32'd0);
    check("wb_busy_idle", {31'd0, busy}, 32'd0);
  endtask

  task automatic read_line(input int a, input int exp_done);
    int first;
    req_v = 1'b1; req_we = 1'b0; req_addr = ADDR_W'(a);
    check("rd_req_rdy_idle", {31'd0, req_rdy}, 32'd1);
    for (int i = 0; i < BEATS; i++) sb.push_back('{model[a*BEATS+i], i == BEATS - 1});
    cyc_n = 0;
    cyc();
    req_v = 1'b0;
    first = rd_v ? cyc_n : 0;
    while (!done && cyc_n < 30) begin
      cyc();
      if (rd_v && first == 0) first = cyc_n;
    end
    check("rd_first_cycle", first, LATENCY + 1);
    check("rd_done_cycle", cyc_n, exp_done);
    check("rd_sb_empty", sb.size(), 0);
    cyc();
    check("rd_done_pulse", {31'd0, done}, 32'd0);
  endtask

  initial begin
    int i;
    logic acc;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b1;
    cyc();

    // Writeback to line 5 with wr_v held high, then fill it back.
    write_line(5, 32'hA0, -1, 0, LATENCY + BEATS + 1, 4'hF);
    read_line(5, LATENCY + BEATS + 1);

    // Writeback to line 2 with a 2-cycle stall after beat 1.
    write_line(2, 32'h20, 1, 2, LATENCY + BEATS + 3, 4'hF);
    read_line(2, LATENCY + BEATS + 1);

    // req_v held through a fill: next accept only after DONE.
    req_v = 1'b1; req_we = 1'b0; req_addr = ADDR_W'(5);
    for (int k = 0; k < BEATS; k++) sb.push_back('{model[5*BEATS+k], k == BEATS - 1});
    cyc_n = 0;
    cyc();
    while (!done && cyc_n < 30) begin
      check("hold_busy", {31'd0, busy}, 32'd1);
      check("hold_req_rdy", {31'd0, req_rdy}, 32'd0);
      cyc();
    end
    check("hold_done_cycle", cyc_n, LATENCY + BEATS + 1);
    check("hold_busy_done", {31'd0, busy}, 32'd1);
    check("hold_req_rdy_done", {31'd0, req_rdy}, 32'd0);
    req_addr = ADDR_W'(2);
    cyc();
    check("hold_req_rdy_after", {31'd0, req_rdy}, 32'd1);
    for (int k = 0; k < BEATS; k++) sb.push_back('{model[2*BEATS+k], k == BEATS - 1});
    cyc_n = 0;
    cyc();
    req_v = 1'b0;
    check("hold_second_accept", {31'd0, busy}, 32'd1);
    while (!done && cyc_n < 30) cyc();
    check("hold2_done_cycle", cyc_n, LATENCY + BEATS + 1);
    check("hold2_sb_empty", sb.size(), 0);
    cyc();

    // Reset during beat 2 of a writeback to line 3.
    write_line(3, 32'hB0, -1, 0, LATENCY + BEATS + 1, 4'hF);
    req_v = 1'b1; req_we = 1'b1; req_addr = ADDR_W'(3); wr_v = 1'b0;
    cyc_n = 0;
    cyc();
    req_v = 1'b0;
    while (!wr_rdy && cyc_n < 20) cyc();
    i = 0;
    while (i < 2 && cyc_n < 30) begin
      wr_v = 1'b1; wr_data = 32'hC0 + 32'(i);
      acc = wr_rdy;
      cyc();
      if (acc) begin
        model[3*BEATS+i] = 32'hC0 + 32'(i);
        i++;
      end
    end
    wr_v = 1'b1; wr_data = 32'hC2;
    #2 rst = 1'b0;
    #1 check_reset_outputs("rst_wb");
    @(posedge clk);
    #1;
    rst = 1'b1;
    wr_v = 1'b0;
    cyc();
    read_line(3, LATENCY + BEATS + 1);

    // Reset during a fill: rd_v must drop at once.
    req_v = 1'b1; req_we = 1'b0; req_addr = ADDR_W'(5);
    for (int k = 0; k < BEATS; k++) sb.push_back('{model[5*BEATS+k], k == BEATS - 1});
    cyc_n = 0;
    cyc();
    req_v = 1'b0;
    while (!rd_v && cyc_n < 20) cyc();
    check("rst_rd_seen", {31'd0, rd_v}, 32'd1);
    #2 rst = 1'b0;
    #1 check_reset_outputs("rst_rd");
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc();

`ifdef BYTE_STRB_EN
    // Strobed writeback over an all-ones word: beat 0 becomes 0xFF22FF44.
    write_line(7, 32'hFFFF_FFFF, -1, 0, LATENCY + BEATS + 1, 4'hF);
    write_line(7, 32'h1122_3344, -1, 0, LATENCY + BEATS + 1, 4'b0101);
    read_line(7, LATENCY + BEATS + 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/line_mem_responder.md
Name: line_mem_responder

Overview:
- Memory-side responder for the cache controller's miss path.
- Services two transaction types, each one full cache line:
  - line-fill read, issued on allocation;
  - dirty-line writeback, issued on eviction.
- Holds the backing store as an internal word array, applies a fixed access latency, then streams or absorbs a burst of BEATS words.
- Sits between the cache controller and the top level; it is the sole backing store in the cache test system.

Parameters:
- ADDR_W, 6, width of the line address; backing store holds 2^ADDR_W lines.
- DATA_W, 32, word width in bits; must be a multiple of 8.
- BEATS, 4, words per line; power of 2, at least 2.
- LATENCY, 3, WAIT cycles between request accept and the first data beat; at least 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_v  in  1  request valid.
- req_we  in  1  1 = writeback, 0 = line fill.
- req_addr  in  ADDR_W  line address.
- req_rdy  out  1  request accepted when req_v and req_rdy are both high at a rising edge.
- wr_v  in  1  writeback beat valid.
- wr_data  in  DATA_W  writeback beat data.
- wr_rdy  out  1  writeback beat accepted when wr_v and wr_rdy are both high.
- rd_v  out  1  fill beat valid; there is no backpressure.
- rd_data  out  DATA_W  fill beat data.
- rd_last  out  1  marks the final fill beat.
- done  out  1  one-cycle pulse when a transaction completes.
- busy  out  1  high in every state except IDLE.

Behaviour:
- State machine: IDLE, WAIT, RBURST, WBURST, DONE. All outputs are Moore outputs decoded from state and counters.
- Reset (rst low, asynchronous):
  - state goes to IDLE; latency counter, beat counter, captured address and captured direction all go to 0;
  - output values during reset: req_rdy=1, busy=0, and wr_rdy, rd_v, rd_last, done all 0;
  - rd_data is don't-care while rd_v=0;
  - array contents are not reset and are preserved across reset.
- IDLE:
  - req_rdy=1.
  - On accept: capture req_addr and req_we, load lat_cnt=LATENCY-1, go to WAIT.
  - With req_v=0, stay in IDLE.
- WAIT:
  - req_rdy=0, busy=1.
  - Decrement lat_cnt each cycle.
  - When lat_cnt==0, go to RBURST if captured we=0, otherwise to WBURST; beat counter is cleared on that edge.
  - Net effect: WAIT lasts exactly LATENCY cycles.
- RBURST:
  - rd_v=1 every cycle for exactly BEATS cycles.
  - rd_data = mem[{addr,beat}], asynchronous array read.
  - beat increments each cycle.
  - rd_last=1 when beat==BEATS-1; on that edge go to DONE.
- WBURST:
  - wr_rdy=1.
  - On wr_v&&wr_rdy: write wr_data to mem[{addr,beat}] and increment beat.
  - With wr_v=0, hold: no write, beat unchanged, no timeout.
  - Accepting beat BEATS-1 moves to DONE.
- DONE: done=1 for one cycle, busy=1, req_rdy=0, then IDLE.
- Timing: a request accepted at edge 0 gives
  - fill: rd_v in cycles LATENCY+1 .. LATENCY+BEATS, done in cycle LATENCY+BEATS+1;
  - writeback with no stalls: same cycle positions, using wr_rdy instead of rd_v.
- Boundaries:
  - req_v while busy is ignored and not queued; the requester must hold req_v until accepted.
  - wr_v outside WBURST is ignored and the array is not written.
  - The beat counter is log2(BEATS) bits; the array index is {addr,beat} and never wraps across lines.
  - Back-to-back requests: the earliest next accept is the cycle after DONE.
  - Reset during WBURST: beats already written stay in the array; the remaining beats are lost.
  - Reset during RBURST: rd_v drops immediately.

Optional Feature:
- Macro: BYTE_STRB_EN.
- Defined:
  - adds input port wr_strb, DATA_W/8 bits;
  - on an accepted writeback beat, byte i of the word is updated only when wr_strb[i]=1; other bytes keep their old value.
  - A beat with wr_strb all 0 still counts as a beat.
- Undefined: no wr_strb port; every accepted beat writes the full word.

Test Plan:
1. Reset, then writeback to addr 5 with beats 0xA0..0xA3 and wr_v held high:
   - wr_rdy rises 3 cycles after accept;
   - 4 accepts; done pulses in cycle 8;
   - mem[20..23] = 0xA0..0xA3.
2. Fill from addr 5:
   - rd_v in cycles 4-7 with rd_data 0xA0, 0xA1, 0xA2, 0xA3;
   - rd_last only with 0xA3; done in cycle 8.
3. Writeback to addr 2 with wr_v dropped for 2 cycles after beat 1:
   - beat 1 is not rewritten; beat 2 lands in mem[10];
   - done is delayed by exactly 2 cycles.
4. req_v held high through a fill:
   - the second request is accepted only in the cycle after done;
   - busy is high throughout.
5. rst pulsed low during beat 2 of a writeback to addr 3:
   - outputs return to reset values at once;
   - mem[12..13] hold the new data, mem[14..15] the old data;
   - a subsequent fill from addr 3 returns that mix.
6. With BYTE_STRB_EN defined:
   - writeback beat 0x11223344 with wr_strb=4'b0101 over old value 0xFFFFFFFF;
   - the word reads back as 0xFF22FF44.
